tmds_gearbox: RTL and testbench

//  Parametrised multi-channel gearbox: pops wide symbol words (one per channel, packed) from a

---
 rtl/tmds_gearbox_if.sv | 28 ++
 rtl/tmds_gearbox.sv | 93 +++++++++
 tb/tb_tmds_gearbox.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/tmds_gearbox_if.sv
// rtl/tmds_gearbox_if.sv - FIFO-head input and sliced-output bundle for tmds_gearbox
interface tmds_gearbox_if #(
    parameter int CHANNELS    = 4,
    parameter int IN_WIDTH    = 10,
    parameter int OUT_WIDTH   = 5,
    parameter int COUNT_WIDTH = 16
);
    localparam int RATIO = IN_WIDTH / OUT_WIDTH;
    localparam int PW    = (RATIO > 2) ? $clog2(RATIO) : 1;

    logic [CHANNELS*IN_WIDTH-1:0]  inData;
    logic                          inValid;
    logic                          inRead;
    logic [CHANNELS*OUT_WIDTH-1:0] outData;
    logic [PW-1:0]                 outPhase;
    logic                          underflow;
    logic [COUNT_WIDTH-1:0]        underflowCount;

    modport master (
        output inData, inValid,
        input  inRead, outData, outPhase, underflow, underflowCount
    );

    modport slave (
        input  inData, inValid,
        output inRead, outData, outPhase, underflow, underflowCount
    );
endinterface

// File: rtl/tmds_gearbox.sv
// rtl/tmds_gearbox.sv - multi-lane wide-symbol to narrow-slice gearbox with idle fill on underflow
module tmds_gearbox #(
    parameter int                  CHANNELS    = 4,
    parameter int                  IN_WIDTH    = 10,
    parameter int                  OUT_WIDTH   = 5,
    parameter bit                  MSB_FIRST   = 1'b1,
    parameter logic [IN_WIDTH-1:0] IDLE_WORD   = 10'b1101010100,
    parameter int                  COUNT_WIDTH = 16
) (
    input  logic           clock,
    input  logic           resetN,
    input  logic           enable,
    tmds_gearbox_if.slave  bus
);
    localparam int RATIO = IN_WIDTH / OUT_WIDTH;
    localparam int PW    = (RATIO > 2) ? $clog2(RATIO) : 1;
    localparam int IW    = CHANNELS * IN_WIDTH;
    localparam int OW    = CHANNELS * OUT_WIDTH;

    localparam logic [IW-1:0] IDLE_FULL  = {CHANNELS{IDLE_WORD}};
    localparam logic [PW-1:0] LAST_PHASE = PW'(RATIO - 1);

    if ((IN_WIDTH % OUT_WIDTH) != 0 || (IN_WIDTH / OUT_WIDTH) < 2) begin : g_bad_params
        $error("tmds_gearbox: IN_WIDTH must be an integer multiple (>=2) of OUT_WIDTH");
    end

    logic [PW-1:0]          phase, phase_next;
    logic [IW-1:0]          word, word_next;
    logic [OW-1:0]          data, data_next;
    logic [PW-1:0]          out_phase;
    logic                   uf, uf_next;
    logic [COUNT_WIDTH-1:0] count, count_next;
    logic                   pop;

    // Every lane is cut at the same offset; slice k counts from the top or bottom of the symbol.
    function automatic logic [OW-1:0] slice_of(input logic [IW-1:0] w, input logic [PW-1:0] k);
        logic [OW-1:0]       r;
        logic [IN_WIDTH-1:0] sym;
        int                  lsb;
        r = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            sym = w[c*IN_WIDTH +: IN_WIDTH];
            lsb = MSB_FIRST ? IN_WIDTH - (int'(k) + 1) * OUT_WIDTH : int'(k) * OUT_WIDTH;
            r[c*OUT_WIDTH +: OUT_WIDTH] = sym[lsb +: OUT_WIDTH];
        end
        return r;
    endfunction

    assign pop = resetN & enable & bus.inValid & (phase == '0);

    always_comb begin
        phase_next = (phase == LAST_PHASE) ? '0 : phase + PW'(1);
        word_next  = word;
        data_next  = slice_of(word, phase);
        uf_next    = 1'b0;
        count_next = count;
        if (phase == '0) begin
            word_next = pop ? bus.inData : IDLE_FULL;
            data_next = slice_of(word_next, '0);
            // Disabled idle is intentional and must not look like a starved FIFO.
            if (!pop && enable) begin
                uf_next = 1'b1;
                if (count != '1) begin
                    count_next = count + COUNT_WIDTH'(1);
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!resetN) begin
            phase     <= '0;
            word      <= IDLE_FULL;
            data      <= '0;
            out_phase <= '0;
            uf        <= 1'b0;
            count     <= '0;
        end else begin
            phase     <= phase_next;
            word      <= word_next;
            data      <= data_next;
            out_phase <= phase;
            uf        <= uf_next;
            count     <= count_next;
        end
    end

    assign bus.inRead         = pop;
    assign bus.outData        = data;
    assign bus.outPhase       = out_phase;
    assign bus.underflow      = uf;
    assign bus.underflowCount = count;
endmodule

// File: tb/tb_tmds_gearbox.sv
// tb/tb_tmds_gearbox.sv - table and scoreboard bench for tmds_gearbox (4x10->5 MSB-first, 2x10->2 LSB-first)
module tb_tmds_gearbox;
    logic clk;
    logic rst_a, en_a, rst_b, en_b;
    int   n_checks = 0;
    int   n_fail   = 0;

    tmds_gearbox_if #(.CHANNELS(4), .IN_WIDTH(10), .OUT_WIDTH(5), .COUNT_WIDTH(16)) ifa ();
    tmds_gearbox_if #(.CHANNELS(2), .IN_WIDTH(10), .OUT_WIDTH(2), .COUNT_WIDTH(4))  ifb ();

    tmds_gearbox #(
        .CHANNELS(4), .IN_WIDTH(10), .OUT_WIDTH(5), .MSB_FIRST(1'b1),
        .IDLE_WORD(10'b1101010100), .COUNT_WIDTH(16)
    ) dut_a (.clock(clk), .resetN(rst_a), .enable(en_a), .bus(ifa.slave));

    tmds_gearbox #(
        .CHANNELS(2), .IN_WIDTH(10), .OUT_WIDTH(2), .MSB_FIRST(1'b0),
        .IDLE_WORD(10'b1101010100), .COUNT_WIDTH(4)
    ) dut_b (.clock(clk), .resetN(rst_b), .enable(en_b), .bus(ifb.slave));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    localparam logic [39:0] W1   = {10'h000, 10'h3FF, 10'h155, 10'h2AB};
    localparam logic [39:0] W2   = {10'h2AB, 10'h000, 10'h3FF, 10'h155};
    localparam logic [19:0] A0W1 = 20'b00000_11111_01010_10101;
    localparam logic [19:0] A1W1 = 20'b00000_11111_10101_01011;
    localparam logic [19:0] A0W2 = 20'b10101_00000_11111_01010;
    localparam logic [19:0] A1W2 = 20'b01011_00000_11111_10101;
    localparam logic [19:0] I0   = {4{5'b11010}};
    localparam logic [19:0] I1   = {4{5'b10100}};
    localparam logic [19:0] WB   = {10'b0000011111, 10'b1110010011};

    typedef struct {
        logic        en;
        logic        valid;
        logic [39:0] data;
        logic        read;
        logic [19:0] out;
        logic        ph;
        logic        uf;
        logic [15:0] cnt;
    } vec_a_t;

    typedef struct {
        logic [19:0] out;
        logic        ph;
        logic        uf;
        logic [15:0] cnt;
    } exp_a_t;

    typedef struct {
        logic [3:0] out;
        logic [2:0] ph;
        logic       uf;
        logic [3:0] cnt;
    } exp_b_t;

    vec_a_t tbl [14];
    exp_a_t sb_a [$];
    exp_b_t sb_b [$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic step_a(input vec_a_t v, input int idx);
        exp_a_t e;
        @(negedge clk);
        rst_a = 1'b1;
        en_a = v.en;
        ifa.inValid = v.valid;
        ifa.inData = v.data;
        #1;
        chk($sformatf("a[%0d] inRead", idx), 64'(ifa.inRead), 64'(v.read));
        sb_a.push_back('{v.out, v.ph, v.uf, v.cnt});
        @(posedge clk);
        #1;
        if (sb_a.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL a[%0d] scoreboard empty", idx);
        end else begin
            e = sb_a.pop_front();
            chk($sformatf("a[%0d] outData", idx), 64'(ifa.outData), 64'(e.out));
            chk($sformatf("a[%0d] outPhase", idx), 64'(ifa.outPhase), 64'(e.ph));
            chk($sformatf("a[%0d] underflow", idx), 64'(ifa.underflow), 64'(e.uf));
            chk($sformatf("a[%0d] count", idx), 64'(ifa.underflowCount), 64'(e.cnt));
        end
    endtask

    task automatic step_b(input string tag, input logic rst, input logic en, input logic valid,
                          input logic read, input logic [3:0] out, input logic [2:0] ph,
                          input logic uf, input logic [3:0] cnt);
        exp_b_t e;
        @(negedge clk);
        rst_b = rst;
        en_b = en;
        ifb.inValid = valid;
        ifb.inData = WB;
        #1;
        chk({tag, " inRead"}, 64'(ifb.inRead), 64'(read));
        sb_b.push_back('{out, ph, uf, cnt});
        @(posedge clk);
        #1;
        if (sb_b.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s scoreboard empty", tag);
        end else begin
            e = sb_b.pop_front();
            chk({tag, " outData"}, 64'(ifb.outData), 64'(e.out));
            chk({tag, " outPhase"}, 64'(ifb.outPhase), 64'(e.ph));
            chk({tag, " underflow"}, 64'(ifb.underflow), 64'(e.uf));
            chk({tag, " count"}, 64'(ifb.underflowCount), 64'(e.cnt));
        end
    endtask

    logic [3:0] idle_b [5];
    logic [3:0] cnt_b;

    initial begin
        rst_a = 1'b0; en_a = 1'b1; ifa.inValid = 1'b0; ifa.inData = '0;
        rst_b = 1'b0; en_b = 1'b1; ifb.inValid = 1'b0; ifb.inData = '0;

        tbl[0]  = '{1'b1, 1'b1, W1, 1'b1, A0W1, 1'b0, 1'b0, 16'd0};
        tbl[1]  = '{1'b1, 1'b1, W2, 1'b0, A1W1, 1'b1, 1'b0, 16'd0};
        tbl[2]  = '{1'b1, 1'b1, W2, 1'b1, A0W2, 1'b0, 1'b0, 16'd0};
        tbl[3]  = '{1'b1, 1'b0, W1, 1'b0, A1W2, 1'b1, 1'b0, 16'd0};
        tbl[4]  = '{1'b1, 1'b0, W1, 1'b0, I0,   1'b0, 1'b1, 16'd1};
        tbl[5]  = '{1'b1, 1'b0, W1, 1'b0, I1,   1'b1, 1'b0, 16'd1};
        tbl[6]  = '{1'b1, 1'b0, W1, 1'b0, I0,   1'b0, 1'b1, 16'd2};
        tbl[7]  = '{1'b1, 1'b1, W1, 1'b0, I1,   1'b1, 1'b0, 16'd2};
        tbl[8]  = '{1'b1, 1'b1, W1, 1'b1, A0W1, 1'b0, 1'b0, 16'd2};
        tbl[9]  = '{1'b0, 1'b1, W2, 1'b0, A1W1, 1'b1, 1'b0, 16'd2};
        tbl[10] = '{1'b0, 1'b1, W2, 1'b0, I0,   1'b0, 1'b0, 16'd2};
        tbl[11] = '{1'b0, 1'b1, W2, 1'b0, I1,   1'b1, 1'b0, 16'd2};
        tbl[12] = '{1'b1, 1'b1, W2, 1'b1, A0W2, 1'b0, 1'b0, 16'd2};
        tbl[13] = '{1'b1, 1'b0, W2, 1'b0, A1W2, 1'b1, 1'b0, 16'd2};

        idle_b[0] = 4'b0000; idle_b[1] = 4'b0101; idle_b[2] = 4'b0101;
        idle_b[3] = 4'b0101; idle_b[4] = 4'b1111;

        // Held in reset with a valid head: no pop, everything at reset value.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            rst_a = 1'b0; en_a = 1'b1; ifa.inValid = 1'b1; ifa.inData = W1;
            #1;
            chk($sformatf("rst[%0d] inRead", i), 64'(ifa.inRead), 64'd0);
            @(posedge clk);
            #1;
            chk($sformatf("rst[%0d] outData", i), 64'(ifa.outData), 64'd0);
            chk($sformatf("rst[%0d] outPhase", i), 64'(ifa.outPhase), 64'd0);
            chk($sformatf("rst[%0d] underflow", i), 64'(ifa.underflow), 64'd0);
            chk($sformatf("rst[%0d] count", i), 64'(ifa.underflowCount), 64'd0);
        end

        for (int i = 0; i < 14; i++) begin
            step_a(tbl[i], i);
        end

        // LSB-first 10->2 slicing, then a reset pulse mid-word.
        step_b("b pop0",  1'b1, 1'b1, 1'b1, 1'b1, 4'b1111, 3'd0, 1'b0, 4'd0);
        step_b("b s1",    1'b1, 1'b1, 1'b1, 1'b0, 4'b1100, 3'd1, 1'b0, 4'd0);
        step_b("b rst",   1'b0, 1'b1, 1'b1, 1'b0, 4'b0000, 3'd0, 1'b0, 4'd0);
        step_b("b pop1",  1'b1, 1'b1, 1'b1, 1'b1, 4'b1111, 3'd0, 1'b0, 4'd0);
        step_b("b s1b",   1'b1, 1'b1, 1'b0, 1'b0, 4'b1100, 3'd1, 1'b0, 4'd0);
        step_b("b s2",    1'b1, 1'b1, 1'b0, 1'b0, 4'b0101, 3'd2, 1'b0, 4'd0);
        step_b("b s3",    1'b1, 1'b1, 1'b0, 1'b0, 4'b0010, 3'd3, 1'b0, 4'd0);
        step_b("b s4",    1'b1, 1'b1, 1'b0, 1'b0, 4'b0011, 3'd4, 1'b0, 4'd0);

        // Starve the small-counter instance past its saturation point.
        cnt_b = 4'd0;
        for (int w = 0; w < 20; w++) begin
            for (int k = 0; k < 5; k++) begin
                if (k == 0 && cnt_b != 4'hF) cnt_b = cnt_b + 4'd1;
                step_b($sformatf("b idle w%0d k%0d", w, k), 1'b1, 1'b1, 1'b0, 1'b0,
                       idle_b[k], 3'(k), (k == 0), cnt_b);
            end
        end
        chk("b count saturated", 64'(ifb.underflowCount), 64'hF);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
